mips_avalon_ram: RTL

// - Avalon-MM slave (responder) word RAM serving the mips_cpu_bus master; sits in the testbench/SoC on the CPU bus.
// - Single port for instruction fetch and data; configurable fixed plus pseudo-random wait states exercise CPU stall handling.
// - Byte-lane writes via byteenable; asynchronous array read; sticky error flag for protocol or address faults.

---
 rtl/mips_avalon_ram.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mips_avalon_ram.sv
// rtl/mips_avalon_ram.sv - Avalon-MM word RAM responder for the mips_cpu_bus master
//
// Purpose: single-port 32-bit word RAM serving instruction fetch and data
// traffic, with a fixed plus optional pseudo-random number of wait states.
// Writes are lane-masked by byteenable. The array read is asynchronous.
// Protocol and address faults set a sticky bus_err flag.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   address      byte address from master (word aligned)
//   write, read  request strobes
//   waitrequest  1 = request not yet accepted
//   writedata    write data
//   byteenable   lane enables, bit n -> writedata[8n+7:8n]
//   readdata     read data, valid while read=1 and waitrequest=0
//   bus_err      sticky fault flag, cleared only by reset
module mips_avalon_ram #(
    parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
    parameter int          DEPTH_WORDS  = 4096,
    parameter int          WAIT_STATES  = 1,
    parameter int          RANDOM_STALL = 0,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] lfsr;
    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic [31:0]   offset;
    logic          in_range;
    logic          fault;
    logic [4:0]    load;
    logic          access;
    logic          lfsr_fb;
    logic [AW-1:0] index;

    assign req      = read | write;
    // Offset wraps in 32 bits, so addresses below BASE_ADDR land far out of range.
    assign offset   = address - BASE_ADDR;
    assign in_range = {1'b0, offset} < (33'(DEPTH_WORDS) << 2);
    assign index    = offset[AW+1:2];
    assign fault    = !in_range || (address[1:0] != 2'b00) || (read && write);

    // Total wait cycles for a request accepted this cycle.
    assign load = 5'(WAIT_STATES) + ((RANDOM_STALL != 0) ? {3'b000, lfsr[1:0]} : 5'd0);

    // Fibonacci taps 16,14,13,11 in right-shift form.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Completing cycle: zero-wait request in IDLE, or the single ACK cycle.
    assign access = reset && req &&
                    (((state == S_IDLE) && (load == 5'd0)) || (state == S_ACK));

    always_comb begin
        waitrequest = 1'b1;
        if (reset) begin
            case (state)
                S_IDLE:  waitrequest = req && (load != 5'd0);
                S_WAIT:  waitrequest = 1'b1;
                S_ACK:   waitrequest = 1'b0;
                default: waitrequest = 1'b1;
            endcase
        end
    end

    always_comb begin
        readdata = 32'h0;
        if (access && read && !fault) readdata = mem[index];
    end

    // RAM contents survive reset; a write only lands on a clean completing edge.
    always_ff @(posedge clk) begin
        if (access && write && !fault) begin
            for (int n = 0; n < 4; n++) begin
                if (byteenable[n]) mem[index][8*n +: 8] <= writedata[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            lfsr    <= 16'hACE1;
            bus_err <= 1'b0;
        end else begin
            if (access && fault) bus_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lfsr <= {lfsr_fb, lfsr[15:1]};
                        // The request cycle itself is the first wait cycle.
                        if (load == 5'd1) begin
                            cnt   <= 5'd1;
                            state <= S_ACK;
                        end else if (load != 5'd0) begin
                            cnt   <= load - 5'd1;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        // Master abandoned the request mid-wait.
                        bus_err <= 1'b1;
                        cnt     <= 5'd0;
                        state   <= S_IDLE;
                    end else if (cnt == 5'd1) begin
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_ACK: begin
                    cnt   <= 5'd0;
                    state <= S_IDLE;
                end
                default: begin
                    cnt   <= 5'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
